// File: rtl/mw_pipe_stage.sv
`default_nettype none
// mw_pipe_stage: MEM->WB pipeline register with valid/ready handshake, optional 2-entry skid, flush.
// Revision 1.0 - initial release
module mw_pipe_stage #(
   parameter int DATA_W     = 32,
   parameter int RN_W       = 5,
   parameter bit SKID_EN    = 1'b1,
   parameter bit ZERO_GUARD = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_m2reg,
   input  logic              in_wreg,
   input  logic [DATA_W-1:0] in_mo,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [RN_W-1:0]   in_rn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_m2reg,
   output logic              out_wreg,
   output logic [DATA_W-1:0] out_mo,
   output logic [DATA_W-1:0] out_alu,
   output logic [RN_W-1:0]   out_rn,
   output logic [DATA_W-1:0] out_wdata,
   output logic [1:0]        occupancy
);

   // Payload layout: {m2reg, wreg, mo, alu, rn, wdata}
   localparam int PL_W = 2 + 3 * DATA_W + RN_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PL_W-1:0]   r_head;
   logic [PL_W-1:0]   r_skid;
   logic [PL_W-1:0]   w_in_pl;
   logic [DATA_W-1:0] w_in_wdata;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_retire;
   logic              w_ld_head_in;
   logic              w_ld_head_skid;
   logic              w_ld_skid;
   logic              w_head_wreg;

   // Writeback select is resolved at capture so the output side is a plain flop.
   assign w_in_wdata = in_m2reg ? in_mo : in_alu;
   assign w_in_pl    = {in_m2reg, in_wreg, in_mo, in_alu, in_rn, w_in_wdata};

   assign out_valid = (r_state != ST_EMPTY);
   assign w_accept  = in_valid & w_in_ready;
   assign w_retire  = out_valid & out_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_head_in   = 1'b0;
      w_ld_head_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt  = ST_ONE;
                  w_ld_head_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_accept && w_retire) begin
                  w_ld_head_in = 1'b1;
               end else if (w_accept) begin
                  if (SKID_EN) begin
                     w_state_nxt = ST_TWO;
                     w_ld_skid   = 1'b1;
                  end
               end else if (w_retire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_retire) begin
                  w_state_nxt    = ST_ONE;
                  w_ld_head_skid = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
      end else if (w_ld_head_in) begin
         r_head <= w_in_pl;
      end else if (w_ld_head_skid) begin
         r_head <= r_skid;
      end
   end

   // Never loaded when the skid is disabled, so it folds away to constant zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid <= '0;
      end else if (w_ld_skid) begin
         r_skid <= w_in_pl;
      end
   end

   generate
      if (SKID_EN) begin : g_skid_ready
         logic r_in_ready;

         // Registered so ready never depends on same-cycle out_ready.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_in_ready <= 1'b1;
            end else begin
               r_in_ready <= (w_state_nxt != ST_TWO);
            end
         end

         assign w_in_ready = r_in_ready;
      end else begin : g_comb_ready
         assign w_in_ready = ~out_valid | out_ready;
      end
   endgenerate

   assign in_ready = w_in_ready;

   assign {out_m2reg, w_head_wreg, out_mo, out_alu, out_rn, out_wdata} = r_head;

   assign out_wreg  = out_valid & w_head_wreg & ~(ZERO_GUARD & (out_rn == '0));
   assign occupancy = r_state;

endmodule
`default_nettype wire
